// File: rtl/rom_loader_if.sv
// Byte-stream input and program-RAM write port of the ROM loader.
// The slave modport is the loader side; master is the byte source / RAM / CPU side.
interface rom_loader_if #(
  parameter int unsigned ADDR_W = 9
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              reload;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_write_en;
  logic              cpu_reset;
  logic              loaded;
  logic              error;

  modport slave (
    input  byte_in, byte_valid, reload,
    output byte_ready, mem_addr, mem_data, mem_write_en, cpu_reset, loaded, error
  );

  modport master (
    output byte_in, byte_valid, reload,
    input  byte_ready, mem_addr, mem_data, mem_write_en, cpu_reset, loaded, error
  );
endinterface

// File: rtl/rom_loader.sv
// Validates an "ASRM" framed byte stream and writes it into program RAM,
// holding the CPU in reset until a checksum-correct image has loaded.
module rom_loader #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned TIMEOUT = 100000
) (
  input logic         clk,
  input logic         reset,
  rom_loader_if.slave bus
);

  localparam logic [2:0] StHunt  = 3'd0;
  localparam logic [2:0] StMagic = 3'd1;
  localparam logic [2:0] StLenLo = 3'd2;
  localparam logic [2:0] StLenHi = 3'd3;
  localparam logic [2:0] StData  = 3'd4;
  localparam logic [2:0] StSum   = 3'd5;
  localparam logic [2:0] StDone  = 3'd6;
  localparam logic [2:0] StError = 3'd7;

  localparam int unsigned TimerW = $clog2(TIMEOUT + 1);
  localparam int unsigned MaxLen = (2 ** ADDR_W) - 4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [7:0]        sum_q, sum_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              error_q, error_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              we_q, we_d;

  logic        byte_ready;
  logic        accept;
  logic        counting;
  logic        timeout;
  logic [15:0] len;
  logic [7:0]  magic_exp;

  assign byte_ready = (state_q != StDone) && (state_q != StError);
  assign accept     = bus.byte_valid && byte_ready;
  assign counting   = (state_q != StHunt) && byte_ready;
  // The timer reaches TIMEOUT on the same edge that moves the FSM to ERROR.
  assign timeout    = counting && (timer_q == TimerW'(TIMEOUT - 1));
  assign len        = {bus.byte_in, len_lo_q};

  always_comb begin
    case (ptr_q[1:0])
      2'd1:    magic_exp = 8'h53;
      2'd2:    magic_exp = 8'h52;
      default: magic_exp = 8'h4d;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    len_lo_d = len_lo_q;
    sum_d    = sum_q;
    error_d  = error_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = 1'b0;
    timer_d  = counting ? timer_q + 1'b1 : '0;

    if (timeout) begin
      state_d = StError;
      error_d = 1'b1;
    end else if (accept) begin
      timer_d = '0;
      case (state_q)
        StHunt: begin
          if (bus.byte_in == 8'h41) begin
            addr_d  = '0;
            data_d  = bus.byte_in;
            we_d    = 1'b1;
            error_d = 1'b0;
            ptr_d   = ADDR_W'(1);
            state_d = StMagic;
          end
        end
        StMagic: begin
          if (bus.byte_in == magic_exp) begin
            addr_d = ptr_q;
            data_d = bus.byte_in;
            we_d   = 1'b1;
            ptr_d  = ptr_q + 1'b1;
            if (ptr_q == ADDR_W'(3)) state_d = StLenLo;
          end else if (bus.byte_in == 8'h41) begin
            addr_d = '0;
            data_d = bus.byte_in;
            we_d   = 1'b1;
            ptr_d  = ADDR_W'(1);
          end else begin
            state_d = StHunt;
          end
        end
        StLenLo: begin
          len_lo_d = bus.byte_in;
          state_d  = StLenHi;
        end
        StLenHi: begin
          ptr_d = ADDR_W'(4);
          sum_d = '0;
          cnt_d = len[ADDR_W-1:0];
          if (32'(len) > MaxLen) begin
            state_d = StError;
            error_d = 1'b1;
          end else if (len == 16'd0) begin
            state_d = StSum;
          end else begin
            state_d = StData;
          end
        end
        StData: begin
          addr_d = ptr_q;
          data_d = bus.byte_in;
          we_d   = 1'b1;
          ptr_d  = ptr_q + 1'b1;
          sum_d  = sum_q + bus.byte_in;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == ADDR_W'(1)) state_d = StSum;
        end
        StSum: begin
          if (bus.byte_in == sum_q) begin
            state_d = StDone;
          end else begin
            state_d = StError;
            error_d = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (bus.reload && !byte_ready) begin
      state_d = StHunt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StHunt;
      ptr_q    <= '0;
      cnt_q    <= '0;
      len_lo_q <= '0;
      sum_q    <= '0;
      timer_q  <= '0;
      error_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      len_lo_q <= len_lo_d;
      sum_q    <= sum_d;
      timer_q  <= timer_d;
      error_q  <= error_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
    end
  end

  assign bus.byte_ready   = byte_ready;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_data     = data_q;
  assign bus.mem_write_en = we_q;
  assign bus.loaded       = (state_q == StDone);
  assign bus.cpu_reset    = (state_q != StDone);
  assign bus.error        = error_q;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: a vector table for the frame flows plus
// hand-written sequences for the full-size load, timeout and mid-frame reset.
module tb_rom_loader;

  typedef struct {
    logic [7:0] b;
    logic       v;
    logic       rl;
    logic       rdy;
    logic       we;
    logic [8:0] addr;
    logic [7:0] data;
    logic       ld;
    logic       cr;
    logic       er;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  vec_t vq[$];
  logic [7:0] tb_mem [512];

  rom_loader_if #(.ADDR_W(9)) bus ();

  rom_loader #(
    .ADDR_W  (9),
    .TIMEOUT (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (bus.mem_write_en) tb_mem[bus.mem_addr] <= bus.mem_data;
  end

  function automatic vec_t mk(logic [7:0] b, logic v, logic rl, logic rdy, logic we,
                              logic [8:0] addr, logic [7:0] data, logic ld, logic cr,
                              logic er);
    vec_t r;
    r.b = b; r.v = v; r.rl = rl; r.rdy = rdy; r.we = we; r.addr = addr; r.data = data;
    r.ld = ld; r.cr = cr; r.er = er;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [7:0] b, input logic v, input logic rl);
    bus.byte_in    = b;
    bus.byte_valid = v;
    bus.reload     = rl;
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    bus.reload     = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".ready"}, 32'(bus.byte_ready), 1);
    check({tag, ".we"}, 32'(bus.mem_write_en), 0);
    check({tag, ".addr"}, 32'(bus.mem_addr), 0);
    check({tag, ".data"}, 32'(bus.mem_data), 0);
    check({tag, ".loaded"}, 32'(bus.loaded), 0);
    check({tag, ".cpu_reset"}, 32'(bus.cpu_reset), 1);
    check({tag, ".error"}, 32'(bus.error), 0);
  endtask

  task automatic apply(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      step(vq[i].b, vq[i].v, vq[i].rl);
      check($sformatf("v%0d.ready", i), 32'(bus.byte_ready), 32'(vq[i].rdy));
      check($sformatf("v%0d.we", i), 32'(bus.mem_write_en), 32'(vq[i].we));
      if (vq[i].we) begin
        check($sformatf("v%0d.addr", i), 32'(bus.mem_addr), 32'(vq[i].addr));
        check($sformatf("v%0d.data", i), 32'(bus.mem_data), 32'(vq[i].data));
      end
      check($sformatf("v%0d.loaded", i), 32'(bus.loaded), 32'(vq[i].ld));
      check($sformatf("v%0d.cpu_reset", i), 32'(bus.cpu_reset), 32'(vq[i].cr));
      check($sformatf("v%0d.error", i), 32'(bus.error), 32'(vq[i].er));
    end
  endtask

  task automatic push_frame1_body();
    vq.push_back(mk(8'h41, 1, 0, 1, 1, 9'h000, 8'h41, 0, 1, 0));
    vq.push_back(mk(8'h53, 1, 0, 1, 1, 9'h001, 8'h53, 0, 1, 0));
    vq.push_back(mk(8'h52, 1, 0, 1, 1, 9'h002, 8'h52, 0, 1, 0));
    vq.push_back(mk(8'h4d, 1, 0, 1, 1, 9'h003, 8'h4d, 0, 1, 0));
    vq.push_back(mk(8'h03, 1, 0, 1, 0, 9'h000, 8'h00, 0, 1, 0));
    vq.push_back(mk(8'h00, 1, 0, 1, 0, 9'h000, 8'h00, 0, 1, 0));
    vq.push_back(mk(8'h14, 1, 0, 1, 1, 9'h004, 8'h14, 0, 1, 0));
    vq.push_back(mk(8'h3c, 1, 0, 1, 1, 9'h005, 8'h3c, 0, 1, 0));
    vq.push_back(mk(8'h10, 1, 0, 1, 1, 9'h006, 8'h10, 0, 1, 0));
  endtask

  initial begin
    logic [7:0] sum;
    logic [7:0] pb;
    logic [7:0] last;
    checks   = 0;
    failures = 0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    bus.reload     = 1'b0;

    // Frame 1 (indices 0..9): good checksum.
    push_frame1_body();
    vq.push_back(mk(8'h60, 1, 0, 0, 0, 9'h000, 8'h00, 1, 0, 0));
    // DONE ignores input, then reload back to HUNT.
    vq.push_back(mk(8'h41, 1, 0, 0, 0, 9'h000, 8'h00, 1, 0, 0));
    vq.push_back(mk(8'h00, 0, 1, 1, 0, 9'h000, 8'h00, 0, 1, 0));
    // Same frame with bad checksum.
    push_frame1_body();
    vq.push_back(mk(8'h61, 1, 0, 0, 0, 9'h000, 8'h00, 0, 1, 1));
    vq.push_back(mk(8'h41, 1, 0, 0, 0, 9'h000, 8'h00, 0, 1, 1));
    vq.push_back(mk(8'h00, 0, 1, 1, 0, 9'h000, 8'h00, 0, 1, 1));
    // 41 41 53 52 4D 00 00 00: resync on second 41 (reload there is ignored), LEN=0.
    vq.push_back(mk(8'h41, 1, 0, 1, 1, 9'h000, 8'h41, 0, 1, 0));
    vq.push_back(mk(8'h41, 1, 1, 1, 1, 9'h000, 8'h41, 0, 1, 0));
    vq.push_back(mk(8'h53, 1, 0, 1, 1, 9'h001, 8'h53, 0, 1, 0));
    vq.push_back(mk(8'h52, 1, 0, 1, 1, 9'h002, 8'h52, 0, 1, 0));
    vq.push_back(mk(8'h4d, 1, 0, 1, 1, 9'h003, 8'h4d, 0, 1, 0));
    vq.push_back(mk(8'h00, 1, 0, 1, 0, 9'h000, 8'h00, 0, 1, 0));
    vq.push_back(mk(8'h00, 1, 0, 1, 0, 9'h000, 8'h00, 0, 1, 0));
    vq.push_back(mk(8'h00, 1, 0, 0, 0, 9'h000, 8'h00, 1, 0, 0));
    vq.push_back(mk(8'h00, 0, 1, 1, 0, 9'h000, 8'h00, 0, 1, 0));
    // Non-41 dropped in HUNT; magic mismatch with non-41 falls back to HUNT.
    vq.push_back(mk(8'h53, 1, 0, 1, 0, 9'h000, 8'h00, 0, 1, 0));
    vq.push_back(mk(8'h41, 1, 0, 1, 1, 9'h000, 8'h41, 0, 1, 0));
    vq.push_back(mk(8'h53, 1, 0, 1, 1, 9'h001, 8'h53, 0, 1, 0));
    vq.push_back(mk(8'h99, 1, 0, 1, 0, 9'h000, 8'h00, 0, 1, 0));
    vq.push_back(mk(8'h52, 1, 0, 1, 0, 9'h000, 8'h00, 0, 1, 0));
    // LEN=01FD is one too many for 512 bytes: ERROR at LEN_HI, no payload writes.
    vq.push_back(mk(8'h41, 1, 0, 1, 1, 9'h000, 8'h41, 0, 1, 0));
    vq.push_back(mk(8'h53, 1, 0, 1, 1, 9'h001, 8'h53, 0, 1, 0));
    vq.push_back(mk(8'h52, 1, 0, 1, 1, 9'h002, 8'h52, 0, 1, 0));
    vq.push_back(mk(8'h4d, 1, 0, 1, 1, 9'h003, 8'h4d, 0, 1, 0));
    vq.push_back(mk(8'hfd, 1, 0, 1, 0, 9'h000, 8'h00, 0, 1, 0));
    vq.push_back(mk(8'h01, 1, 0, 0, 0, 9'h000, 8'h00, 0, 1, 1));
    vq.push_back(mk(8'h00, 0, 0, 0, 0, 9'h000, 8'h00, 0, 1, 1));
    vq.push_back(mk(8'h00, 0, 1, 1, 0, 9'h000, 8'h00, 0, 1, 1));

    // Asynchronous reset values, seen before any clock edge.
    reset = 1'b1;
    #3;
    check_reset_values("rst0");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    apply(0, vq.size() - 1);
    check("frame1.mem4", 32'(tb_mem[4]), 32'h14);
    check("frame1.mem6", 32'(tb_mem[6]), 32'h10);

    // LEN=01FC: fills RAM exactly up to 1FF.
    step(8'h41, 1, 0);
    check("big.err_clr", 32'(bus.error), 0);
    step(8'h53, 1, 0);
    step(8'h52, 1, 0);
    step(8'h4d, 1, 0);
    step(8'hfc, 1, 0);
    step(8'h01, 1, 0);
    check("big.ready", 32'(bus.byte_ready), 1);
    sum  = 8'h00;
    last = 8'h00;
    for (int k = 0; k < 508; k++) begin
      pb   = 8'(k) ^ 8'h5a;
      sum  = sum + pb;
      last = pb;
      step(pb, 1, 0);
      if (k == 0) check("big.first_addr", 32'(bus.mem_addr), 32'h004);
      if (k == 507) begin
        check("big.last_we", 32'(bus.mem_write_en), 1);
        check("big.last_addr", 32'(bus.mem_addr), 32'h1ff);
        check("big.last_data", 32'(bus.mem_data), 32'(last));
      end
    end
    step(sum, 1, 0);
    check("big.loaded", 32'(bus.loaded), 1);
    check("big.cpu_reset", 32'(bus.cpu_reset), 0);
    check("big.mem1ff", 32'(tb_mem[511]), 32'(last));
    check("big.mem004", 32'(tb_mem[4]), 32'h5a);

    // Stream stalls after 2 payload bytes: ERROR exactly 16 cycles later.
    step(8'h00, 0, 1);
    step(8'h41, 1, 0);
    step(8'h53, 1, 0);
    step(8'h52, 1, 0);
    step(8'h4d, 1, 0);
    step(8'h05, 1, 0);
    step(8'h00, 1, 0);
    step(8'haa, 1, 0);
    step(8'hbb, 1, 0);
    for (int k = 1; k <= 16; k++) begin
      step(8'h00, 0, 0);
      check($sformatf("tmo.c%0d.error", k), 32'(bus.error), (k == 16) ? 1 : 0);
    end
    check("tmo.ready", 32'(bus.byte_ready), 0);
    check("tmo.cpu_reset", 32'(bus.cpu_reset), 1);

    // Reset in the middle of DATA, then a fresh frame.
    step(8'h00, 0, 1);
    step(8'h41, 1, 0);
    step(8'h53, 1, 0);
    step(8'h52, 1, 0);
    step(8'h4d, 1, 0);
    step(8'h03, 1, 0);
    step(8'h00, 1, 0);
    step(8'h14, 1, 0);
    check("mid.we", 32'(bus.mem_write_en), 1);
    #3;
    reset = 1'b1;
    #1;
    check_reset_values("rst1");
    @(posedge clk);
    #3;
    reset = 1'b0;
    apply(0, 9);
    check("after_rst.mem5", 32'(tb_mem[5]), 32'h3c);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
